crono_timer_param: RTL and testbench

//  Parametrised countdown-chronometer controller, successor to the fixed 4-state crono FSM.

---
 rtl/crono_timer_param_if.sv | 23 ++
 rtl/crono_timer_param.sv | 134 +++++++++++++
 tb/tb_crono_timer_param.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/crono_timer_param_if.sv
// Control/status bundle of the countdown chronometer: user requests in, count and alarm status out.
interface crono_timer_param_if #(parameter int CNT_W = 12);
  logic             prog_en;
  logic [CNT_W-1:0] prog_value;
  logic             start;
  logic             stop;
  logic             ring_ack;
  logic [CNT_W-1:0] remaining;
  logic             crono_activo;
  logic             ring;
  logic             done_pulse;
  logic [1:0]       state;

  modport master (
    output prog_en, prog_value, start, stop, ring_ack,
    input  remaining, crono_activo, ring, done_pulse, state
  );

  modport slave (
    input  prog_en, prog_value, start, stop, ring_ack,
    output remaining, crono_activo, ring, done_pulse, state
  );
endinterface

// File: rtl/crono_timer_param.sv
// Countdown chronometer: programmable preset, prescaled countdown, pause/resume, bounded ring; `define CRONO_AUTORELOAD_EN for periodic reload.
// Latency: first decrement PRESCALE clk after start is sampled; no backpressure, inputs are sampled every clk.
module crono_timer_param #(
  parameter int CNT_W      = 12,
  parameter int PRESCALE   = 256,
  parameter int RING_TICKS = 4
) (
  input logic                clk,
  input logic                Reset,
  crono_timer_param_if.slave bus
);

  typedef enum logic [1:0] {
    PROG = 2'b00,
    IDLE = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam int PW = $clog2(PRESCALE);
  localparam int RW = $clog2(RING_TICKS + 1);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [RW-1:0]    RING_MAX  = RW'(RING_TICKS - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, preset_q;
  logic [PW-1:0]    presc_q;
  logic [RW-1:0]    ring_cnt_q;
  logic             crono_q, ring_q, done_q;
  logic             crono_d, ring_d, done_d;
  logic             tick, live, expire;

  assign tick   = (state_q == RUN || state_q == DONE) && (presc_q == PRESC_MAX);
  assign live   = !bus.prog_en && !bus.stop;
  // A stop on the final tick wins, so expiry needs both programming and pause to be idle.
  assign expire = (state_q == RUN) && live && tick && (remaining_q == ONE);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state_q <= PROG;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PROG: if (!bus.prog_en) state_d = IDLE;
      IDLE: begin
        if (bus.prog_en)                                         state_d = PROG;
        else if (!bus.stop && bus.start && remaining_q != '0)    state_d = RUN;
      end
      RUN: begin
        if (bus.prog_en)   state_d = PROG;
        else if (bus.stop) state_d = IDLE;
`ifndef CRONO_AUTORELOAD_EN
        else if (expire)   state_d = DONE;
`endif
      end
      DONE: begin
        if (bus.prog_en)                          state_d = PROG;
        else if (bus.ring_ack)                    state_d = IDLE;
        else if (tick && ring_cnt_q == RING_MAX)  state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    crono_d = (state_d == RUN);
    done_d  = expire;
`ifdef CRONO_AUTORELOAD_EN
    // Ring window opens on each expiry and closes after RING_TICKS ticks, on ack, or on leaving RUN.
    ring_d  = (state_d == RUN) &&
              (expire || (ring_q && !bus.ring_ack && !(tick && ring_cnt_q == RING_MAX)));
`else
    ring_d  = (state_d == DONE);
`endif
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      crono_q <= 1'b0;
      ring_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      crono_q <= crono_d;
      ring_q  <= ring_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      remaining_q <= '0;
      preset_q    <= '0;
      presc_q     <= '0;
      ring_cnt_q  <= '0;
    end else begin
      if (state_d == RUN || state_d == DONE)
        presc_q <= (state_d != state_q || tick) ? '0 : presc_q + PW'(1);
      else
        presc_q <= '0;

      if (bus.prog_en) begin
        preset_q    <= bus.prog_value;
        remaining_q <= bus.prog_value;
      end else if (expire) begin
`ifdef CRONO_AUTORELOAD_EN
        remaining_q <= preset_q;
`else
        remaining_q <= '0;
`endif
      end else if (state_q == RUN && live && tick && remaining_q != '0) begin
        remaining_q <= remaining_q - ONE;
      end else if (state_q == DONE && state_d == IDLE) begin
        remaining_q <= preset_q;
      end

`ifdef CRONO_AUTORELOAD_EN
      if (expire)              ring_cnt_q <= '0;
      else if (ring_q && tick) ring_cnt_q <= ring_cnt_q + RW'(1);
`else
      if (state_d == DONE && state_q != DONE) ring_cnt_q <= '0;
      else if (state_q == DONE && tick)       ring_cnt_q <= ring_cnt_q + RW'(1);
`endif
    end
  end

  assign bus.remaining    = remaining_q;
  assign bus.crono_activo = crono_q;
  assign bus.ring         = ring_q;
  assign bus.done_pulse   = done_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_crono_timer_param.sv
// Directed bench for crono_timer_param with CNT_W=8, PRESCALE=4, RING_TICKS=2.
module tb_crono_timer_param;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  crono_timer_param_if #(.CNT_W(8)) bus ();

  crono_timer_param #(.CNT_W(8), .PRESCALE(4), .RING_TICKS(2)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    bit       pe;
    bit [7:0] pv;
    bit       st;
    bit       sp;
    bit       ack;
    int       ncyc;
    bit [1:0] e_state;
    bit [7:0] e_rem;
    bit       e_ring;
    bit       e_act;
    bit       e_done;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  function automatic vec_t v(bit pe, bit [7:0] pv, bit st, bit sp, bit ack, int ncyc,
                             bit [1:0] es, bit [7:0] er, bit eg, bit ea, bit ed);
    vec_t r;
    r.pe = pe; r.pv = pv; r.st = st; r.sp = sp; r.ack = ack; r.ncyc = ncyc;
    r.e_state = es; r.e_rem = er; r.e_ring = eg; r.e_act = ea; r.e_done = ed;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit pe, input bit [7:0] pv, input bit st, input bit sp, input bit ack);
    bus.prog_en = pe; bus.prog_value = pv; bus.start = st; bus.stop = sp; bus.ring_ack = ack;
  endtask

  task automatic chk_all(input string nm, input bit [1:0] es, input bit [7:0] er,
                         input bit eg, input bit ea, input bit ed);
    chk({nm, ".state"}, int'(bus.state), int'(es));
    chk({nm, ".rem"},   int'(bus.remaining), int'(er));
    chk({nm, ".ring"},  int'(bus.ring), int'(eg));
    chk({nm, ".act"},   int'(bus.crono_activo), int'(ea));
    chk({nm, ".done"},  int'(bus.done_pulse), int'(ed));
  endtask

  initial begin
    Reset = 1'b1;
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    cyc(2);
    chk_all("reset", 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;

`ifndef CRONO_AUTORELOAD_EN
    //        pe pv  st sp ak n   state  rem  rg ac dn
    vecs.push_back(v(1, 3, 0, 0, 0, 1, 2'b00, 3, 0, 0, 0));  // program 3
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 2'b01, 3, 0, 0, 0));  // -> IDLE
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 2'b10, 3, 0, 1, 0));  // start at T
    vecs.push_back(v(0, 0, 0, 0, 0, 3, 2'b10, 3, 0, 1, 0));  // T+3
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 2'b10, 2, 0, 1, 0));  // T+4
    vecs.push_back(v(0, 0, 0, 0, 0, 4, 2'b10, 1, 0, 1, 0));  // T+8
    vecs.push_back(v(0, 0, 0, 0, 0, 3, 2'b10, 1, 0, 1, 0));  // T+11
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 2'b11, 0, 1, 0, 1));  // T+12 expiry
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 2'b11, 0, 1, 0, 0));  // pulse is one clk
    vecs.push_back(v(0, 0, 0, 0, 0, 6, 2'b11, 0, 1, 0, 0));  // T+19 still ringing
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 2'b01, 3, 0, 0, 0));  // T+20 ring timeout
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 2'b10, 3, 0, 1, 0));  // start at T'
    vecs.push_back(v(0, 0, 0, 0, 0, 4, 2'b10, 2, 0, 1, 0));  // T'+4
    vecs.push_back(v(0, 0, 0, 1, 0, 1, 2'b01, 2, 0, 0, 0));  // stop at T'+5
    vecs.push_back(v(0, 0, 0, 1, 0, 19, 2'b01, 2, 0, 0, 0)); // paused
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 2'b10, 2, 0, 1, 0));  // resume T'+25
    vecs.push_back(v(0, 0, 0, 0, 0, 3, 2'b10, 2, 0, 1, 0));  // T'+28
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 2'b10, 1, 0, 1, 0));  // T'+29
    vecs.push_back(v(0, 0, 0, 0, 0, 3, 2'b10, 1, 0, 1, 0));  // one before final tick
    vecs.push_back(v(0, 0, 0, 1, 0, 1, 2'b01, 1, 0, 0, 0));  // stop beats final tick
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 2'b10, 1, 0, 1, 0));  // resume
    vecs.push_back(v(0, 0, 0, 0, 0, 4, 2'b11, 0, 1, 0, 1));  // expiry
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 2'b01, 3, 0, 0, 0));  // ring_ack -> IDLE, reload
    vecs.push_back(v(0, 0, 1, 0, 0, 1, 2'b10, 3, 0, 1, 0));  // start
    vecs.push_back(v(1, 5, 0, 0, 0, 1, 2'b00, 5, 0, 0, 0));  // prog_en during RUN
    vecs.push_back(v(1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));  // program 0
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0));  // IDLE
    vecs.push_back(v(0, 0, 1, 0, 0, 3, 2'b01, 0, 0, 0, 0));  // start ignored at 0
    vecs.push_back(v(1, 2, 0, 0, 0, 1, 2'b00, 2, 0, 0, 0));  // program 2
    vecs.push_back(v(0, 0, 1, 1, 0, 2, 2'b01, 2, 0, 0, 0));  // stop outranks start in IDLE

    foreach (vecs[i]) begin
      drive(vecs[i].pe, vecs[i].pv, vecs[i].st, vecs[i].sp, vecs[i].ack);
      cyc(vecs[i].ncyc);
      chk_all($sformatf("row%0d", i), vecs[i].e_state, vecs[i].e_rem,
              vecs[i].e_ring, vecs[i].e_act, vecs[i].e_done);
    end
`else
    drive(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
    cyc(1);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk_all("ar_start", 2'b10, 8'd3, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      chk_all($sformatf("ar_k%0d", k), 2'b10, 8'(3 - (k % 12) / 4),
              (k >= 12) && ((k % 12) < 8), 1'b1, (k % 12) == 0);
    end
    drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    cyc(1);
    chk_all("ar_stop", 2'b01, 8'd2, 1'b0, 1'b0, 1'b0);
`endif

    // Asynchronous reset while the alarm is ringing.
    drive(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    cyc(1);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    cyc(1);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    cyc(4);
    chk("pre_rst.ring", int'(bus.ring), 1);
    chk("pre_rst.done", int'(bus.done_pulse), 1);
    #2 Reset = 1'b1;
    #1 chk_all("mid_rst", 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    Reset = 1'b0;
    cyc(1);
    chk("post_rst.state", int'(bus.state), 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
